// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared constants and helpers for the decode-side fetch redirect controller.
// Opcode/funct encodings and the npc source selector live here so every file agrees.
package fetch_redirect_ctrl_pkg;

  localparam int WORD_WIDTH = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_BRANCH,
    NPC_JUMP,
    NPC_JR
  } npc_sel_e;

  // Register 0 is hardwired to zero, so it can never carry a dependence.
  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch/decode handshake bundle between the fetch stage and the redirect controller.
// master = pipeline side feeding operands and pc/instr, slave = the controller.
interface fetch_redirect_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
);
  logic [WIDTH-1:0] pcF;
  logic [WIDTH-1:0] instrF;
  logic [WIDTH-1:0] rs_dataD;
  logic [WIDTH-1:0] rt_dataD;
  logic             memreadE;
  logic             regwriteE;
  logic [4:0]       writeregE;
  logic             memreadM;
  logic [4:0]       writeregM;
  logic [WIDTH-1:0] npc;
  logic             stallF;
  logic             stallD;
  logic             flushE;
  logic [WIDTH-1:0] instrD;
  logic [WIDTH-1:0] pcD;
  logic             validD;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] redir_cnt;

  modport master (
    output pcF, instrF, rs_dataD, rt_dataD, memreadE, regwriteE, writeregE,
           memreadM, writeregM,
    input  npc, stallF, stallD, flushE, instrD, pcD, validD, stall_cnt, redir_cnt
  );

  modport slave (
    input  pcF, instrF, rs_dataD, rt_dataD, memreadE, regwriteE, writeregE,
           memreadM, writeregM,
    output npc, stallF, stallD, flushE, instrD, pcD, validD, stall_cnt, redir_cnt
  );
endinterface

// File: rtl/fetch_redirect_ctrl_hazard_detect.sv
// Purely combinational stall detection for the instruction in ID: load-use and
// operand hazards on branches/jr that resolve in ID. Shared with the ID/EX control.
module fetch_redirect_ctrl_hazard_detect
  import fetch_redirect_ctrl_pkg::*;
(
  input  logic       validD,
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [5:0] funct,
  input  logic       memreadE,
  input  logic       regwriteE,
  input  logic [4:0] writeregE,
  input  logic       memreadM,
  input  logic [4:0] writeregM,
  output logic       stall
);
  logic is_branch;
  logic is_jr;
  logic uses_rt;
  logic load_use;
  logic hit_e;
  logic hit_m;
  logic ctrl_hazard;

  always_comb begin
    is_branch = (op == OP_BEQ) || (op == OP_BNE);
    is_jr     = (op == OP_RTYPE) && (funct == FUNCT_JR);
    uses_rt   = (op == OP_RTYPE) || is_branch || (op == OP_SW);
    load_use  = memreadE &&
                (reg_hit(rs, writeregE) || (uses_rt && reg_hit(rt, writeregE)));
    // jr only reads rs; branches compare rs against rt.
    hit_e       = reg_hit(rs, writeregE) || (is_branch && reg_hit(rt, writeregE));
    hit_m       = reg_hit(rs, writeregM) || (is_branch && reg_hit(rt, writeregM));
    ctrl_hazard = (is_branch || is_jr) &&
                  ((regwriteE && hit_e) || (memreadM && hit_m));
    stall       = validD && (load_use || ctrl_hazard);
  end
endmodule

// File: rtl/fetch_redirect_ctrl.sv
// IF/ID pipeline register, branch/jump resolution in ID, npc selection back to
// fetch, and saturating stall/redirect performance counters.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int CNT_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  fetch_redirect_ctrl_if.slave bus
);
  logic [WIDTH-1:0] instrD_q, instrD_d;
  logic [WIDTH-1:0] pcD_q, pcD_d;
  logic             validD_q, validD_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

  logic [5:0]       op;
  logic [5:0]       funct;
  logic [15:0]      imm;
  logic             is_branch, is_jr, is_jump, taken, stall, redirect;
  logic [WIDTH-1:0] pcD_plus4, pcF_plus4, br_target, j_target;
  npc_sel_e         npc_sel;

  assign op    = instrD_q[31:26];
  assign funct = instrD_q[5:0];
  assign imm   = instrD_q[15:0];

  fetch_redirect_ctrl_hazard_detect u_hazard (
    .validD    (validD_q),
    .op        (op),
    .rs        (instrD_q[25:21]),
    .rt        (instrD_q[20:16]),
    .funct     (funct),
    .memreadE  (bus.memreadE),
    .regwriteE (bus.regwriteE),
    .writeregE (bus.writeregE),
    .memreadM  (bus.memreadM),
    .writeregM (bus.writeregM),
    .stall     (stall)
  );

  always_comb begin
    is_branch = (op == OP_BEQ) || (op == OP_BNE);
    is_jr     = (op == OP_RTYPE) && (funct == FUNCT_JR);
    is_jump   = (op == OP_J) || (op == OP_JAL);
    taken     = ((op == OP_BEQ) && (bus.rs_dataD == bus.rt_dataD)) ||
                ((op == OP_BNE) && (bus.rs_dataD != bus.rt_dataD)) ||
                is_jump || is_jr;
    // A stall wins; the redirect is simply re-evaluated once it clears.
    redirect  = validD_q && taken && !stall;

    pcF_plus4 = bus.pcF + WIDTH'(4);
    pcD_plus4 = pcD_q + WIDTH'(4);
    br_target = pcD_plus4 + {{(WIDTH-18){imm[15]}}, imm, 2'b00};
    j_target  = {pcD_plus4[WIDTH-1:28], instrD_q[25:0], 2'b00};

    npc_sel = NPC_SEQ;
    if (redirect) begin
      if (is_branch)  npc_sel = NPC_BRANCH;
      else if (is_jr) npc_sel = NPC_JR;
      else            npc_sel = NPC_JUMP;
    end
  end

  always_comb begin
    case (npc_sel)
      NPC_BRANCH: bus.npc = br_target;
      NPC_JUMP:   bus.npc = j_target;
      NPC_JR:     bus.npc = bus.rs_dataD;
      default:    bus.npc = pcF_plus4;
    endcase
    bus.stallF    = stall;
    bus.stallD    = stall;
    bus.flushE    = stall;
    bus.instrD    = instrD_q;
    bus.pcD       = pcD_q;
    bus.validD    = validD_q;
    bus.stall_cnt = stall_cnt_q;
    bus.redir_cnt = redir_cnt_q;
  end

  always_comb begin
    instrD_d = instrD_q;
    pcD_d    = pcD_q;
    validD_d = validD_q;
    if (!stall) begin
      // On redirect the fetched instruction is wrong-path: replace it with a bubble.
      instrD_d = redirect ? '0 : bus.instrF;
      validD_d = !redirect;
      pcD_d    = bus.pcF;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    redir_cnt_d = redir_cnt_q;
    if (redirect && !(&redir_cnt_q))
      redir_cnt_d = redir_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrD_q    <= '0;
      pcD_q       <= '0;
      validD_q    <= 1'b0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      instrD_q    <= instrD_d;
      pcD_q       <= pcD_d;
      validD_q    <= validD_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios plus randomized instruction
// streams checked against a behavioural model of the ID stage.
module tb_fetch_redirect_ctrl;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fetch_redirect_ctrl_if #(.WIDTH(32), .CNT_W(CNT_W)) bus ();

  fetch_redirect_ctrl #(.WIDTH(32), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Model of the ID stage contents and the counters.
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  bit          m_valid;
  int          m_scnt;
  int          m_rcnt;
  logic [31:0] last_npc;
  bit          last_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int f_op(input logic [31:0] i);  return int'(i >> 26); endfunction
  function automatic int f_rs(input logic [31:0] i);  return int'((i >> 21) & 31); endfunction
  function automatic int f_rt(input logic [31:0] i);  return int'((i >> 16) & 31); endfunction
  function automatic int f_fn(input logic [31:0] i);  return int'(i & 63); endfunction

  function automatic bit dep(input int src, input int dst);
    return src != 0 && src == dst;
  endfunction

  function automatic bit m_stall();
    int  op = f_op(m_instr);
    int  rs = f_rs(m_instr);
    int  rt = f_rt(m_instr);
    bit  br = (op == 4) || (op == 5);
    bit  jr = (op == 0) && (f_fn(m_instr) == 8);
    bit  urt = (op == 0) || br || (op == 'h2b);
    int  we = int'(bus.writeregE);
    int  wm = int'(bus.writeregM);
    bit  lu, bh;
    lu = bus.memreadE && (dep(rs, we) || (urt && dep(rt, we)));
    bh = (br || jr) &&
         ((bus.regwriteE && (dep(rs, we) || (br && dep(rt, we)))) ||
          (bus.memreadM  && (dep(rs, wm) || (br && dep(rt, wm)))));
    return m_valid && (lu || bh);
  endfunction

  function automatic bit m_taken();
    int op = f_op(m_instr);
    if (op == 4) return bus.rs_dataD == bus.rt_dataD;
    if (op == 5) return bus.rs_dataD != bus.rt_dataD;
    if (op == 2 || op == 3) return 1;
    return (op == 0) && (f_fn(m_instr) == 8);
  endfunction

  function automatic logic [31:0] m_target();
    int op = f_op(m_instr);
    int imm = int'(m_instr & 32'hFFFF);
    int simm = (imm >= 32768) ? imm - 65536 : imm;
    if (op == 4 || op == 5) return m_pc + 32'd4 + 32'(simm * 4);
    if (op == 2 || op == 3) return ((m_pc + 32'd4) & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
    return bus.rs_dataD;
  endfunction

  task automatic m_reset();
    m_instr = 0; m_pc = 0; m_valid = 0; m_scnt = 0; m_rcnt = 0;
  endtask

  // Inputs are already driven (just after a negedge); check, then advance one edge.
  task automatic step();
    bit          e_stall, e_redir;
    logic [31:0] e_npc;
    #1;
    e_stall = m_stall();
    e_redir = m_valid && m_taken() && !e_stall;
    e_npc   = e_redir ? m_target() : bus.pcF + 32'd4;
    chk("stallF", 32'(bus.stallF), 32'(e_stall));
    chk("stallD", 32'(bus.stallD), 32'(e_stall));
    chk("flushE", 32'(bus.flushE), 32'(e_stall));
    if (!e_stall) chk("npc", bus.npc, e_npc);
    chk("instrD", bus.instrD, m_instr);
    chk("validD", 32'(bus.validD), 32'(m_valid));
    if (m_valid) chk("pcD", bus.pcD, m_pc);
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_scnt));
    chk("redir_cnt", 32'(bus.redir_cnt), 32'(m_rcnt));
    last_npc   = e_npc;
    last_stall = e_stall;
    @(posedge clk);
    #1;
    if (!e_stall) begin
      if (e_redir) begin
        m_instr = 0; m_valid = 0;
      end else begin
        m_instr = bus.instrF; m_pc = bus.pcF; m_valid = 1;
      end
    end
    if (e_stall && m_scnt < CNT_MAX) m_scnt++;
    if (e_redir && m_rcnt < CNT_MAX) m_rcnt++;
    @(negedge clk);
  endtask

  task automatic quiet();
    bus.memreadE = 0; bus.regwriteE = 0; bus.writeregE = 0;
    bus.memreadM = 0; bus.writeregM = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] rs = 32'($urandom_range(0, 3));
    logic [31:0] rt = 32'($urandom_range(0, 3));
    logic [31:0] imm = 32'($urandom_range(0, 65535));
    case ($urandom_range(0, 7))
      0: return (32'h04 << 26) | (rs << 21) | (rt << 16) | imm;
      1: return (32'h05 << 26) | (rs << 21) | (rt << 16) | imm;
      2: return (32'h02 << 26) | (32'($urandom) & 32'h03FF_FFFF);
      3: return (32'h03 << 26) | (32'($urandom) & 32'h03FF_FFFF);
      4: return (rs << 21) | 32'h08;
      5: return (rs << 21) | (rt << 16) | (32'd3 << 11) | 32'h20;
      6: return (32'h23 << 26) | (rs << 21) | (rt << 16) | imm;
      default: return (32'h2b << 26) | (rs << 21) | (rt << 16) | imm;
    endcase
  endfunction

  localparam logic [31:0] ADD_321 = (32'd2 << 21) | (32'd1 << 16) | (32'd3 << 11) | 32'h20;
  localparam logic [31:0] BEQ_113 = (32'h04 << 26) | (32'd1 << 21) | (32'd1 << 16) | 32'd3;
  localparam logic [31:0] JR_31   = (32'd31 << 21) | 32'h08;
  localparam logic [31:0] BNE_12  = (32'h05 << 26) | (32'd1 << 21) | (32'd2 << 16) | 32'd8;

  logic [31:0] f_pc;

  initial begin
    m_reset();
    quiet();
    bus.pcF = 0; bus.instrF = 0; bus.rs_dataD = 0; bus.rt_dataD = 0;
    repeat (2) @(negedge clk);
    chk("rst_validD", 32'(bus.validD), 32'd0);
    chk("rst_instrD", bus.instrD, 32'd0);
    chk("rst_npc", bus.npc, 32'd4);
    chk("rst_stallF", 32'(bus.stallF), 32'd0);
    chk("rst_cnt", 32'(bus.stall_cnt) + 32'(bus.redir_cnt), 32'd0);
    rst = 0;

    // Straight-line code.
    for (int i = 0; i < 3; i++) begin
      bus.pcF = 32'(i * 4); bus.instrF = ADD_321;
      step();
      chk("seq_npc", last_npc, 32'(i * 4 + 4));
    end
    chk("seq_validD", 32'(bus.validD), 32'd1);
    chk("seq_stallcnt", 32'(bus.stall_cnt), 32'd0);

    // Load-use: lw $2 in EX while add $3,$2,$1 sits in ID.
    bus.pcF = 32'hC; bus.memreadE = 1; bus.writeregE = 2;
    step();
    chk("lu_stall", 32'(last_stall), 32'd1);
    chk("lu_hold", bus.instrD, ADD_321);
    quiet();
    step();

    // beq $1,$1,+3 at 0x10.
    bus.pcF = 32'h10; bus.instrF = BEQ_113;
    step();
    bus.pcF = 32'h14; bus.instrF = ADD_321; bus.rs_dataD = 32'h55; bus.rt_dataD = 32'h55;
    step();
    chk("beq_npc", last_npc, 32'h20);
    chk("beq_bubble", 32'(bus.validD), 32'd0);
    chk("beq_redir", 32'(bus.redir_cnt), 32'd1);

    // jr $31 with $31 being written in EX.
    bus.pcF = 32'h20; bus.instrF = JR_31;
    step();
    bus.pcF = 32'h24; bus.rs_dataD = 32'h1234_5678; bus.regwriteE = 1; bus.writeregE = 31;
    step();
    chk("jr_stall", 32'(last_stall), 32'd1);
    quiet();
    step();
    chk("jr_npc", last_npc, 32'h1234_5678);

    // bne with equal operands falls through.
    bus.pcF = 32'h30; bus.instrF = BNE_12;
    step();
    bus.pcF = 32'h34; bus.instrF = ADD_321; bus.rs_dataD = 7; bus.rt_dataD = 7;
    step();
    chk("bne_npc", last_npc, 32'h38);

    // Randomized streams; pc starts near the top to exercise wrap-around.
    f_pc = 32'hFFFF_FFE0;
    for (int n = 0; n < 600; n++) begin
      bus.pcF       = f_pc;
      bus.instrF    = rand_instr();
      bus.rs_dataD  = 32'($urandom_range(0, 3));
      bus.rt_dataD  = 32'($urandom_range(0, 3));
      bus.memreadE  = ($urandom_range(0, 3) == 0);
      bus.regwriteE = ($urandom_range(0, 1) == 0);
      bus.writeregE = 5'($urandom_range(0, 3));
      bus.memreadM  = ($urandom_range(0, 3) == 0);
      bus.writeregM = 5'($urandom_range(0, 3));
      step();
      f_pc = last_stall ? bus.pcF : last_npc;
    end
    chk("sat_stall", 32'(bus.stall_cnt), 32'(CNT_MAX));
    chk("sat_redir", 32'(bus.redir_cnt), 32'(CNT_MAX));

    // Asynchronous reset mid-run with a valid instruction in ID.
    quiet();
    bus.pcF = 32'h40; bus.instrF = ADD_321;
    step();
    chk("pre_rst_valid", 32'(bus.validD), 32'd1);
    #2 rst = 1;
    #1;
    chk("arst_validD", 32'(bus.validD), 32'd0);
    chk("arst_instrD", bus.instrD, 32'd0);
    chk("arst_pcD", bus.pcD, 32'd0);
    chk("arst_scnt", 32'(bus.stall_cnt), 32'd0);
    chk("arst_rcnt", 32'(bus.redir_cnt), 32'd0);
    m_reset();
    @(negedge clk);
    rst = 0;
    bus.pcF = 32'h80;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
